mem_datos_arbiter: RTL

- Two-port arbiter and sequencer in front of the data memory (Mem_datos); port A is the CPU load/store unit, port B is the debug/loader port.
- Grants one transaction at a time, round-robin, and drives the memory's active-low Mem_rd/Mem_wr strobes.
- Captures the memory's registered read data and returns it with a one-cycle ack; flags unmapped or misaligned addresses without touching the memory.

---
 rtl/mem_datos_arbiter_if.sv | 14 +
 rtl/mem_datos_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mem_datos_arbiter_if.sv
// One requester port of the Mem_datos arbiter: request/write-data from the
// requester, completion/error/read-data back from the arbiter.
interface mem_datos_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic        err;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, input ack, err, rdata);
    modport slave  (input req, we, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/mem_datos_arbiter.sv
// Round-robin two-port arbiter/sequencer for the data memory: one transaction
// at a time, active-low strobes, registered read capture and one-cycle acks.
module mem_datos_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          NUM_WORDS = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    mem_datos_arbiter_if.slave         a_if,
    mem_datos_arbiter_if.slave         b_if,
    output logic                       Mem_rd,
    output logic                       Mem_wr,
    output logic [31:0]                Dir_Mem,
    output logic [31:0]                Dato_Mem_in,
    input  logic [31:0]                Dato_Mem_out
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, DONE} state_t;

    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * NUM_WORDS);

    state_t           state_q, state_d;
    logic             owner_q, owner_d;      // 0 = port A, 1 = port B
    logic             we_q, we_d;
    logic             err_q, err_d;
    logic             last_b_q, last_b_d;    // last grant went to B
    logic             mem_rd_q, mem_rd_d;
    logic             mem_wr_q, mem_wr_d;
    logic [31:0]      dir_q, dir_d;
    logic [31:0]      din_q, din_d;
    logic [1:0]       ack_q, ack_d;
    logic [1:0]       perr_q, perr_d;
    logic [1:0][31:0] rdata_q, rdata_d;

    logic        pick_b;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_err;

    // On contention the port that did not win last time gets the grant.
    assign pick_b    = b_if.req && (!a_if.req || !last_b_q);
    assign sel_we    = pick_b ? b_if.we    : a_if.we;
    assign sel_addr  = pick_b ? b_if.addr  : a_if.addr;
    assign sel_wdata = pick_b ? b_if.wdata : a_if.wdata;
    assign sel_err   = (sel_addr[1:0] != 2'b00)
                    || ({1'b0, sel_addr} < {1'b0, BASE_ADDR})
                    || ({1'b0, sel_addr} >= LIMIT);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        err_d    = err_q;
        last_b_d = last_b_q;
        mem_rd_d = mem_rd_q;
        mem_wr_d = mem_wr_q;
        dir_d    = dir_q;
        din_d    = din_q;
        ack_d    = ack_q;
        perr_d   = perr_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (a_if.req || b_if.req) begin
                    owner_d  = pick_b;
                    we_d     = sel_we;
                    err_d    = sel_err;
                    dir_d    = sel_addr;
                    din_d    = sel_wdata;
                    // Faulty addresses never strobe the memory.
                    mem_rd_d = sel_err | sel_we;
                    mem_wr_d = sel_err | ~sel_we;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                mem_rd_d = 1'b1;
                mem_wr_d = 1'b1;
                state_d  = CAPT;
            end
            CAPT: begin
                ack_d[owner_q]  = 1'b1;
                perr_d[owner_q] = err_q;
                if (!we_q)
                    rdata_d[owner_q] = err_q ? 32'h0 : Dato_Mem_out;
                state_d = DONE;
            end
            DONE: begin
                ack_d    = 2'b00;
                perr_d   = 2'b00;
                last_b_d = owner_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            last_b_q <= 1'b1;
            mem_rd_q <= 1'b1;
            mem_wr_q <= 1'b1;
            dir_q    <= 32'h0;
            din_q    <= 32'h0;
            ack_q    <= 2'b00;
            perr_q   <= 2'b00;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            err_q    <= err_d;
            last_b_q <= last_b_d;
            mem_rd_q <= mem_rd_d;
            mem_wr_q <= mem_wr_d;
            dir_q    <= dir_d;
            din_q    <= din_d;
            ack_q    <= ack_d;
            perr_q   <= perr_d;
            rdata_q  <= rdata_d;
        end
    end

    assign Mem_rd      = mem_rd_q;
    assign Mem_wr      = mem_wr_q;
    assign Dir_Mem     = dir_q;
    assign Dato_Mem_in = din_q;
    assign a_if.ack    = ack_q[0];
    assign a_if.err    = perr_q[0];
    assign a_if.rdata  = rdata_q[0];
    assign b_if.ack    = ack_q[1];
    assign b_if.err    = perr_q[1];
    assign b_if.rdata  = rdata_q[1];

    a_no_dual_strobe: assert property (@(posedge clk) disable iff (!rst_n)
        !(!mem_rd_q && !mem_wr_q));
endmodule
